// File: rtl/ctrl_word_uart_tx.sv
// Buffers control-register words written by the bus and ships each one over a UART 8N1 link,
// least-significant byte first, with busy/full/overflow status for the CPU side.
module ctrl_word_uart_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ctrl_data,
    input  logic                  ctrl_valid,
    input  logic                  clr_overflow,
    output logic                  tx,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  word_sent
);

    // state    | meaning
    // ST_IDLE  | line high; pops the head word as soon as the FIFO is non-empty
    // ST_START | start bit (tx=0) for one bit time
    // ST_DATA  | eight data bits of the current byte, LSB first
    // ST_STOP  | stop bit (tx=1); chains to the next byte or ends the word

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BAUD_W-1:0]     baud_nxt;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_nxt;
    logic [BYTE_W-1:0]     byte_idx;
    logic [BYTE_W-1:0]     byte_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic                  tx_nxt;
    logic                  word_sent_nxt;

    logic push;
    logic drop;
    logic pop;

    // Full is judged on the registered flag, so a pop at the same edge never rescues a strobe.
    assign push = ctrl_valid && !fifo_full;
    assign drop = ctrl_valid && fifo_full;
    assign pop  = (state == ST_IDLE) && (count != '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ctrl_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_nxt;
            fifo_full <= (count_nxt == CNT_FULL);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // The shift register moves one place per data bit, so after eight bits the next byte sits at [7:0].
    always_comb begin
        state_nxt     = state;
        baud_nxt      = baud_cnt;
        bit_nxt       = bit_idx;
        byte_nxt      = byte_idx;
        shreg_nxt     = shreg;
        tx_nxt        = tx;
        word_sent_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (pop) begin
                    shreg_nxt = mem[rd_ptr];
                    byte_nxt  = '0;
                    baud_nxt  = BAUD_MAX;
                    state_nxt = ST_START;
                    tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_cnt == '0) begin
                    state_nxt = ST_DATA;
                    bit_nxt   = 3'd0;
                    baud_nxt  = BAUD_MAX;
                    tx_nxt    = shreg[0];
                end else begin
                    baud_nxt = baud_cnt - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_cnt == '0) begin
                    baud_nxt  = BAUD_MAX;
                    shreg_nxt = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = shreg[1];
                    end
                end else begin
                    baud_nxt = baud_cnt - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_cnt == '0) begin
                    if (byte_idx != LAST_BYTE) begin
                        byte_nxt  = byte_idx + BYTE_W'(1);
                        baud_nxt  = BAUD_MAX;
                        state_nxt = ST_START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt     = ST_IDLE;
                        word_sent_nxt = 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt - BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            word_sent <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            byte_idx  <= byte_nxt;
            shreg     <= shreg_nxt;
            tx        <= tx_nxt;
            word_sent <= word_sent_nxt;
            busy      <= (count_nxt != '0) || (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ctrl_word_uart_tx.sv
// Checks ctrl_word_uart_tx cycle by cycle against a word-queue / frame-timeline model of the link.
module tb_ctrl_word_uart_tx;

    localparam int DW    = 32;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NB    = DW / 8;
    localparam int FRAME = NB * 10 * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] ctrl_data = '0;
    logic          ctrl_valid = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          tx;
    logic          busy;
    logic          fifo_full;
    logic          overflow;
    logic          word_sent;

    ctrl_word_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_data   (ctrl_data),
        .ctrl_valid  (ctrl_valid),
        .clr_overflow(clr_overflow),
        .tx          (tx),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .word_sent   (word_sent)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ws_seen = 0;

    // Reference: pending words, the word on the wire and how far into its frame we are.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_cur;
    bit            m_in_frame;
    int            m_t;
    bit            m_ovf;
    bit            m_ws;

    function automatic logic frame_bit(input int t, input logic [DW-1:0] w);
        int bitn;
        int bytn;
        int pos;
        bitn = t / CPB;
        bytn = bitn / 10;
        pos  = bitn % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return w[bytn * 8 + pos - 1];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_in_frame = 0;
        m_t        = 0;
        m_ovf      = 0;
        m_ws       = 0;
        m_cur      = '0;
    endtask

    task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic c);
        bit full_pre;
        full_pre = (m_q.size() == DEPTH);
        m_ws = 0;
        if (m_in_frame) begin
            m_t++;
            if (m_t == FRAME) begin
                m_in_frame = 0;
                m_ws       = 1;
            end
        end else if (m_q.size() != 0) begin
            m_cur      = m_q.pop_front();
            m_in_frame = 1;
            m_t        = 0;
        end
        if (v && !full_pre) m_q.push_back(d);
        if (v && full_pre) m_ovf = 1;
        else if (c) m_ovf = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_tx;
        exp_tx = m_in_frame ? frame_bit(m_t, m_cur) : 1'b1;
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("busy", 32'(busy), 32'(m_in_frame || (m_q.size() != 0)));
        chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("word_sent", 32'(word_sent), 32'(m_ws));
    endtask

    task automatic tick(input logic v, input logic [DW-1:0] d, input logic c);
        ctrl_valid   = v;
        ctrl_data    = d;
        clr_overflow = c;
        @(posedge clk);
        cyc++;
        model_edge(v, d, c);
        #1;
        if (word_sent === 1'b1) ws_seen++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, $urandom, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_in_frame || m_q.size() != 0) && n < 2000) begin
            tick(1'b0, $urandom, 1'b0);
            n++;
        end
        chk("drain_timeout", 32'(n < 2000), 32'd1);
        idle(2);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        #1;
        do_reset();

        // Single word: line falls the edge after the pop, word_sent exactly one frame later.
        tick(1'b1, 32'hA55A0F01, 1'b0);
        chk("single_latency_idle", 32'(tx), 32'd1);
        tick(1'b0, '0, 1'b0);
        chk("single_start_low", 32'(tx), 32'd0);
        n = 0;
        while (word_sent !== 1'b1 && n < 300) begin
            tick(1'b0, $urandom, 1'b0);
            n++;
        end
        chk("single_frame_len", 32'(n), 32'd160);
        chk("single_busy_fall", 32'(busy), 32'd0);
        idle(3);

        // Burst of six back-to-back strobes, then clear-vs-drop priority.
        ws_seen = 0;
        for (int w = 1; w <= 6; w++) begin
            tick(1'b1, DW'(w), 1'b0);
            if (w == 5) chk("burst_full_after5", 32'(fifo_full), 32'd1);
        end
        chk("burst_overflow", 32'(overflow), 32'd1);
        tick(1'b1, 32'hDEAD0007, 1'b1);
        chk("clr_with_drop_keeps", 32'(overflow), 32'd1);
        tick(1'b0, '0, 1'b1);
        chk("clr_alone_clears", 32'(overflow), 32'd0);
        drain();
        chk("burst_word_count", 32'(ws_seen), 32'd5);

        // Push at the very edge the FSM pops, with two words already queued.
        tick(1'b1, 32'h0000AAAA, 1'b0);
        tick(1'b1, 32'h0000BBBB, 1'b0);
        tick(1'b1, 32'h0000CCCC, 1'b0);
        n = 0;
        while (m_in_frame && n < 300) begin
            tick(1'b0, $urandom, 1'b0);
            n++;
        end
        chk("coincide_queued", 32'(m_q.size()), 32'd2);
        tick(1'b1, 32'h0000DDDD, 1'b0);
        chk("coincide_full_flag", 32'(fifo_full), 32'd0);
        drain();

        // Randomized traffic with occasional bursts and clears.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 37) == 0 || (i % 700 < 6), $urandom, ($urandom % 150) == 0);
        end
        drain();

        // Reset while the second byte's data bits are on the wire.
        tick(1'b1, 32'hCAFEF00D, 1'b0);
        tick(1'b1, 32'h0BADBEEF, 1'b0);
        n = 0;
        while (!(m_in_frame && m_t == 10 * CPB + 3 * CPB + 1) && n < 500) begin
            tick(1'b0, $urandom, 1'b0);
            n++;
        end
        chk("midframe_reached", 32'(n < 500), 32'd1);
        chk("midframe_busy", 32'(busy), 32'd1);
        do_reset();
        idle(3);
        tick(1'b1, 32'h12345678, 1'b0);
        drain();

        // Quiet bus after reset.
        do_reset();
        ws_seen = 0;
        idle(1000);
        chk("quiet_no_word_sent", 32'(ws_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ctrl_word_uart_tx.md
Name: ctrl_word_uart_tx

Overview:
- Downstream consumer of the bus-written 32-bit control register and its one-cycle write-strobe ("done").
- Each strobe captures the current control word into a small FIFO.
- Each word is serialized to the robot link as UART 8N1 bytes, least-significant byte first.
- Decouples CPU write rate from the slow serial link and reports busy and overflow status.

Parameters:
- DATA_WIDTH, 32, control word width; must be a multiple of 8; NBYTES = DATA_WIDTH/8.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.
- FIFO_DEPTH, 4, word entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- ctrl_data  input  DATA_WIDTH  control word from control register output
- ctrl_valid  input  1  one-cycle write strobe from control register (done)
- clr_overflow  input  1  clears sticky overflow flag
- tx  output  1  UART serial line, idle high, registered
- busy  output  1  high while FIFO non-empty or FSM not IDLE
- fifo_full  output  1  FIFO count == FIFO_DEPTH
- overflow  output  1  sticky; a strobe was dropped
- word_sent  output  1  one-cycle pulse after final stop bit of a word

Behaviour:
- Reset (async, any time, including mid-frame): takes effect immediately.
  - tx=1, busy=0, fifo_full=0, overflow=0, word_sent=0.
  - FIFO emptied, FSM=IDLE, all counters 0.
  - A frame in progress is aborted; no partial bytes resume after reset release.
- Capture:
  - At an edge with ctrl_valid=1, ctrl_data is pushed if fifo_full=0 before that edge.
  - If fifo_full=1, the word is dropped and overflow is set, even if a pop occurs at the same edge.
  - Push and pop at the same edge leave count unchanged.
- overflow: set by a drop; cleared by clr_overflow. Set and clear at the same edge leaves it set.
- FSM states: IDLE, START, DATA, STOP. Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter.
  - IDLE: tx=1. If FIFO non-empty at an edge, pop the head word into the shift register, byte_idx=0, go to START; tx=0 from that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx = current byte bit bit_idx, LSB first. After 8 bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx < NBYTES-1: byte_idx+1 and go to START directly (no idle gap);
    - otherwise: word_sent=1 for one cycle and go to IDLE.
- IDLE lasts at least one cycle between words, so the inter-word gap is exactly 1 cycle of tx=1 when the FIFO is non-empty.
- Latency: a word pushed into an empty FIFO with FSM in IDLE drives tx low starting at the next edge.
- Word frame length: NBYTES*10*CLKS_PER_BIT cycles.
- Counter widths: baud counter clog2(CLKS_PER_BIT); FIFO pointers clog2(FIFO_DEPTH) bits, wrap naturally; count clog2(FIFO_DEPTH)+1 bits.
- busy, fifo_full: registered, consistent with FIFO/FSM state after each edge.

Test Plan:
- Single word (CLKS_PER_BIT=4): ctrl_data=0xA55A0F01, one ctrl_valid pulse -> tx low the next cycle.
  - Bytes 0x01, 0x0F, 0x5A, 0xA5 sent; each is start 0, 8 bits LSB-first, stop 1, every bit 4 cycles.
  - word_sent pulses once 160 cycles after the start bit begins; busy falls the same cycle.
- Burst overflow: 6 ctrl_valid pulses on consecutive cycles with words 1..6 -> word 1 popped immediately, words 2-5 buffered.
  - fifo_full=1 after the 5th strobe; word 6 dropped and overflow=1.
  - Exactly 5 words transmitted in order 1..5 with 1-cycle gaps; 5 word_sent pulses.
- Overflow clear: with overflow=1, assert clr_overflow together with a dropped strobe -> overflow stays 1.
  - clr_overflow alone next cycle -> overflow=0.
- Reset mid-frame: assert rst during DATA of byte 2 -> tx=1, busy=0, fifo_full=0 immediately.
  - After release, push 0x12345678 -> clean frame 0x78, 0x56, 0x34, 0x12 with no residue of the aborted word.
- Quiet bus: 1000 cycles with ctrl_valid=0 after reset -> tx=1, busy=0, word_sent never pulses.
- Push/pop coincidence: FIFO count 2 while FSM IDLE, strobe at the pop edge -> count stays 2 and word order preserved.
